arm_sc_controller: RTL and testbench
====================================

# arm_sc_controller

Control unit for the single-cycle ARM datapath. It decodes the fetched 32-bit instruction into every datapath control strobe and evaluates the ARM condition field against a registered NZCV flag file. It holds the only architectural state outside the register file: the flags and a retired-instruction counter. It sits beside the datapath, taking `INSTRUCTION` and `ALUFlags` and driving all of the datapath's select and enable inputs.

## Interface
- `WIDTH`, default 32: width of the retired-instruction counter.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `INSTRUCTION`  in  32: current instruction (cond [31:28], op [27:26], funct [25:20], Rd [15:12]).
- `ALUFlags`  in  4: live ALU flags, {N,Z,C,V} = [3:0].
- `PCSrc`, `RegWrite`, `MemWrite`, `MemtoReg`, `ALUSrc`  out  1 each: datapath strobes.
- `rotate_control`, `after_shifter_select`, `RdSrc`, `WdSrc`  out  1 each: shifter and link selects.
- `ImmSrc`, `RegSrc`  out  2 each: extender mode and register-address selects.
- `ALUControl`  out  4: ALU operation.
- `CarryIn`  out  1: stored C flag, for ADC/SBC/RSC.
- `Flags`  out  4: stored {N,Z,C,V}.
- `instr_count`  out  WIDTH: count of retired (condition-passed, defined) instructions.

## Operation
- **CondEx**: standard 16-entry ARM condition check against the stored flags. EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE as in ARM; 1110 is always; 1111 is never.
- **Data-processing, op=00**
  - Fields: I=funct[5], cmd=funct[4:1], S=funct[0].
  - `ALUControl`=cmd. `ALUSrc`=I. `rotate_control`=I. `ImmSrc`=00. `RegSrc`=00. `after_shifter_select`=0. `MemtoReg`=0.
  - `RegWrite` = CondEx & ~(cmd==10xx). TST, TEQ, CMP and CMN never write a register.
  - `PCSrc` = `RegWrite` & (Rd==1111).
  - Register-shifted-register forms are not supported; bit 4 is ignored.
- **Memory, op=01**
  - Fields: L=funct[0], U=funct[3]. Immediate offset only.
  - `ALUSrc`=1. `ImmSrc`=01. `after_shifter_select`=1. `rotate_control`=0.
  - `ALUControl`=0100 (ADD) if U=1, 0010 (SUB) if U=0.
  - `RegSrc`=10 for STR, 00 for LDR.
  - `MemWrite` = CondEx & ~L. `RegWrite` = CondEx & L. `MemtoReg` = L.
  - `PCSrc` = `RegWrite` & (Rd==1111).
- **Branch, op=10**
  - `ImmSrc`=10. `ALUSrc`=1. `after_shifter_select`=1. `RegSrc`=01 (RA1=R15, giving PC+8). `ALUControl`=0100.
  - `PCSrc` = CondEx. L=funct[4] selects BL; see Configuration.
- **op=11 (undefined)**: all enables 0, all selects 0. Flags are unchanged and the instruction is not counted.
- **Flag update**: when FlagWE = CondEx & op==00 & (S | cmd==10xx):
  - N and Z are loaded from `ALUFlags`.
  - C and V are loaded only for arithmetic cmds (0010–0111, 1010, 1011).
  - For logical cmds C and V hold.
- **Counter**: `instr_count` increments by 1 per cycle in which CondEx=1 and op≠11. It wraps from 2^WIDTH−1 to 0.
- `RdSrc`, `WdSrc`, `MemWrite`, `MemtoReg` default to 0 whenever they are not explicitly driven above.

## Timing
- All strobes are combinational from `INSTRUCTION` and the stored flags. Zero latency; they are valid within the same cycle.
- The flags register loads on the rising edge at the end of the flag-setting instruction's cycle. The next instruction's CondEx sees the new flags. An instruction never sees its own flag result.
- Asserting `reset` low has these effects:
  - `Flags`=0000, `instr_count`=0, immediately (asynchronous).
  - `RegWrite`, `MemWrite` and `PCSrc` are forced to 0 combinationally for as long as `reset` is low.
- Reset mid-instruction: that instruction is discarded. No flag update and no count on the edge where `reset` is low.
- First rising edge after `reset` goes high: normal decode and update resume with no dead cycle.
- Counter increment and flag update in the same cycle are independent and both occur.

## Configuration
- `ARM_CTRL_BL_EN` defined:
  - BL (op=10, L=1) with CondEx=1 drives `RegWrite`=1, `RdSrc`=1 (Rd=R14) and `WdSrc`=1 (data=PC+4), alongside `PCSrc`=1.
  - For B, and for every non-branch instruction, `RdSrc`=`WdSrc`=0.
- `ARM_CTRL_BL_EN` undefined:
  - BL decodes exactly as B. No link write.
  - `RdSrc` and `WdSrc` are tied to 0.

## Test plan
- Reset low with `INSTRUCTION`=0xE3A01005 (MOV R1,#5) -> `RegWrite`=0, `Flags`=0000, `instr_count`=0. Release reset -> `RegWrite`=1, `ALUSrc`=1, `ALUControl`=1101. After one edge, `instr_count`=1.
- 0xE2510001 (SUBS R0,R1,#1) with `ALUFlags`=0110 -> after the edge `Flags`=0110. Then 0x0A000002 (BEQ) -> `PCSrc`=1. Then 0x1A000002 (BNE) -> `PCSrc`=0, `instr_count` unchanged.
- Stored C=1, V=0, then 0xE2110000 (ANDS) with `ALUFlags`=1001 -> `Flags`=1010 (C and V hold).
- 0xE5821004 (STR R1,[R2,#4]) -> `MemWrite`=1, `RegWrite`=0, `RegSrc`=10, `ImmSrc`=01, `ALUControl`=0100. 0xE5121004 (LDR, U=0) -> `RegWrite`=1, `MemtoReg`=1, `ALUControl`=0010.
- 0xEB000004 (BL) -> with the macro: `PCSrc`=1, `RegWrite`=1, `RdSrc`=1, `WdSrc`=1. Without the macro: `RegWrite`=0, `RdSrc`=`WdSrc`=0.
- 0xEC000000 (op=11) -> all enables 0, `Flags` and `instr_count` unchanged. Preload `instr_count`=0xFFFFFFFF, retire one instruction -> 0.

Source files
------------

// File: rtl/arm_sc_controller.sv
// arm_sc_controller: instruction decoder, NZCV flag file and retired-instruction counter
// for the single-cycle ARM datapath. Optional feature macro: ARM_CTRL_BL_EN (BL link write).
module arm_sc_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      INSTRUCTION,
  input  logic [3:0]       ALUFlags,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             ALUSrc,
  output logic             rotate_control,
  output logic             after_shifter_select,
  output logic             RdSrc,
  output logic             WdSrc,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic [3:0]       ALUControl,
  output logic             CarryIn,
  output logic [3:0]       Flags,
  output logic [WIDTH-1:0] instr_count
);

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  logic [3:0]       w_cond;
  logic [1:0]       w_op;
  logic [5:0]       w_funct;
  logic [3:0]       w_rd;
  logic [3:0]       w_cmd;
  logic             w_n, w_z, w_c, w_v;
  logic             w_cond_ex;
  logic             w_flag_we;
  logic             w_arith;
  logic             w_retire;
  logic             w_reg_write;
  logic             w_mem_write;
  logic             w_pc_src;
  logic             w_unused;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_instr_count;

  assign w_cond   = INSTRUCTION[31:28];
  assign w_op     = INSTRUCTION[27:26];
  assign w_funct  = INSTRUCTION[25:20];
  assign w_rd     = INSTRUCTION[15:12];
  assign w_cmd    = w_funct[4:1];
  assign w_unused = ^{INSTRUCTION[19:16], INSTRUCTION[11:0]};

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_cond_ex = 1'b0;
    case (w_cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_src             = 1'b0;
    w_reg_write          = 1'b0;
    w_mem_write          = 1'b0;
    MemtoReg             = 1'b0;
    ALUSrc               = 1'b0;
    rotate_control       = 1'b0;
    after_shifter_select = 1'b0;
    RdSrc                = 1'b0;
    WdSrc                = 1'b0;
    ImmSrc               = 2'b00;
    RegSrc               = 2'b00;
    ALUControl           = 4'b0000;
    case (w_op)
      OP_DP: begin
        ALUControl     = w_cmd;
        ALUSrc         = w_funct[5];
        rotate_control = w_funct[5];
        // Compare/test commands (10xx) only set flags.
        w_reg_write    = w_cond_ex & (w_cmd[3:2] != 2'b10);
        w_pc_src       = w_reg_write & (w_rd == 4'hF);
      end
      OP_MEM: begin
        ALUSrc               = 1'b1;
        ImmSrc               = 2'b01;
        after_shifter_select = 1'b1;
        ALUControl           = w_funct[3] ? 4'b0100 : 4'b0010;
        RegSrc               = w_funct[0] ? 2'b00 : 2'b10;
        w_mem_write          = w_cond_ex & ~w_funct[0];
        w_reg_write          = w_cond_ex & w_funct[0];
        MemtoReg             = w_funct[0];
        w_pc_src             = w_reg_write & (w_rd == 4'hF);
      end
      OP_BR: begin
        ImmSrc               = 2'b10;
        ALUSrc               = 1'b1;
        after_shifter_select = 1'b1;
        RegSrc               = 2'b01;
        ALUControl           = 4'b0100;
        w_pc_src             = w_cond_ex;
`ifdef ARM_CTRL_BL_EN
        if (w_funct[4] && w_cond_ex) begin
          w_reg_write = 1'b1;
          RdSrc       = 1'b1;
          WdSrc       = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // Architectural write enables are suppressed for the whole time reset is held low.
  assign RegWrite = w_reg_write & reset;
  assign MemWrite = w_mem_write & reset;
  assign PCSrc    = w_pc_src & reset;

  assign w_flag_we = w_cond_ex & (w_op == OP_DP) & (w_funct[0] | (w_cmd[3:2] == 2'b10));
  assign w_arith   = (w_cmd inside {[4'b0010:4'b0111], 4'b1010, 4'b1011});
  assign w_retire  = w_cond_ex & (w_op != OP_UND);

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if (w_flag_we) begin
      r_flags[3:2] <= ALUFlags[3:2];
      if (w_arith) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_count <= '0;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + WIDTH'(1);
    end
  end

  assign Flags       = r_flags;
  assign CarryIn     = r_flags[1];
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_arm_sc_controller.sv
// Scoreboard bench for arm_sc_controller: directed instructions push expected values,
// a negedge monitor pops and compares them against the live outputs.
module tb_arm_sc_controller;

  typedef enum int {
    F_PCSRC, F_REGWRITE, F_MEMWRITE, F_MEMTOREG, F_ALUSRC, F_RDSRC, F_WDSRC,
    F_IMMSRC, F_REGSRC, F_ALUCTL, F_CARRYIN, F_FLAGS, F_CNT, F_CNT4
  } field_e;

  typedef struct {
    string       name;
    field_e      f;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] INSTRUCTION;
  logic [3:0]  ALUFlags;

  logic        PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc;
  logic        rotate_control, after_shifter_select, RdSrc, WdSrc, CarryIn;
  logic [1:0]  ImmSrc, RegSrc;
  logic [3:0]  ALUControl, Flags;
  logic [31:0] instr_count;

  logic        w4_pcsrc, w4_regwrite, w4_memwrite, w4_memtoreg, w4_alusrc;
  logic        w4_rot, w4_after, w4_rdsrc, w4_wdsrc, w4_carryin;
  logic [1:0]  w4_immsrc, w4_regsrc;
  logic [3:0]  w4_aluctl, w4_flags;
  logic [3:0]  w4_count;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  arm_sc_controller #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .INSTRUCTION(INSTRUCTION), .ALUFlags(ALUFlags),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .rotate_control(rotate_control),
    .after_shifter_select(after_shifter_select), .RdSrc(RdSrc), .WdSrc(WdSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .CarryIn(CarryIn),
    .Flags(Flags), .instr_count(instr_count)
  );

  // Narrow counter instance, used to exercise the wrap to zero.
  arm_sc_controller #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .INSTRUCTION(INSTRUCTION), .ALUFlags(ALUFlags),
    .PCSrc(w4_pcsrc), .RegWrite(w4_regwrite), .MemWrite(w4_memwrite),
    .MemtoReg(w4_memtoreg), .ALUSrc(w4_alusrc), .rotate_control(w4_rot),
    .after_shifter_select(w4_after), .RdSrc(w4_rdsrc), .WdSrc(w4_wdsrc),
    .ImmSrc(w4_immsrc), .RegSrc(w4_regsrc), .ALUControl(w4_aluctl),
    .CarryIn(w4_carryin), .Flags(w4_flags), .instr_count(w4_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] get_field(field_e f);
    case (f)
      F_PCSRC:    return 32'(PCSrc);
      F_REGWRITE: return 32'(RegWrite);
      F_MEMWRITE: return 32'(MemWrite);
      F_MEMTOREG: return 32'(MemtoReg);
      F_ALUSRC:   return 32'(ALUSrc);
      F_RDSRC:    return 32'(RdSrc);
      F_WDSRC:    return 32'(WdSrc);
      F_IMMSRC:   return 32'(ImmSrc);
      F_REGSRC:   return 32'(RegSrc);
      F_ALUCTL:   return 32'(ALUControl);
      F_CARRYIN:  return 32'(CarryIn);
      F_FLAGS:    return 32'(Flags);
      F_CNT:      return instr_count;
      F_CNT4:     return 32'(w4_count);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string name, input field_e f, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.f    = f;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = get_field(e.f);
      n_vec++;
      if (act !== e.exp) begin
        n_miss++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b0;
    INSTRUCTION = 32'hE3A01005;
    ALUFlags    = 4'b0000;

    go();
    expect_val("rst_regwrite", F_REGWRITE, 32'd0);
    expect_val("rst_flags",    F_FLAGS,    32'h0);
    expect_val("rst_count",    F_CNT,      32'd0);

    go(); reset = 1'b1;
    expect_val("mov_regwrite", F_REGWRITE, 32'd1);
    expect_val("mov_alusrc",   F_ALUSRC,   32'd1);
    expect_val("mov_aluctl",   F_ALUCTL,   32'hD);
    expect_val("mov_count0",   F_CNT,      32'd0);

    go(); INSTRUCTION = 32'hE2510001; ALUFlags = 4'b0110;
    expect_val("subs_count1",  F_CNT,      32'd1);
    expect_val("subs_aluctl",  F_ALUCTL,   32'h2);

    go(); INSTRUCTION = 32'h0A000002; ALUFlags = 4'b0000;
    expect_val("subs_flags",   F_FLAGS,    32'h6);
    expect_val("beq_pcsrc",    F_PCSRC,    32'd1);
    expect_val("beq_immsrc",   F_IMMSRC,   32'h2);
    expect_val("beq_count",    F_CNT,      32'd2);

    go(); INSTRUCTION = 32'h1A000002;
    expect_val("bne_pcsrc",    F_PCSRC,    32'd0);
    expect_val("bne_count",    F_CNT,      32'd3);

    go(); INSTRUCTION = 32'hE2110000; ALUFlags = 4'b1001;
    expect_val("ands_count",   F_CNT,      32'd3);
    expect_val("ands_carryin", F_CARRYIN,  32'd1);

    go(); INSTRUCTION = 32'hE5821004;
    expect_val("ands_flags",   F_FLAGS,    32'hA);
    expect_val("str_memwrite", F_MEMWRITE, 32'd1);
    expect_val("str_regwrite", F_REGWRITE, 32'd0);
    expect_val("str_regsrc",   F_REGSRC,   32'h2);
    expect_val("str_immsrc",   F_IMMSRC,   32'h1);
    expect_val("str_aluctl",   F_ALUCTL,   32'h4);
    expect_val("str_count",    F_CNT,      32'd4);

    go(); INSTRUCTION = 32'hE5121004;
    expect_val("ldr_regwrite", F_REGWRITE, 32'd1);
    expect_val("ldr_memtoreg", F_MEMTOREG, 32'd1);
    expect_val("ldr_memwrite", F_MEMWRITE, 32'd0);
    expect_val("ldr_aluctl",   F_ALUCTL,   32'h2);
    expect_val("ldr_pcsrc",    F_PCSRC,    32'd0);
    expect_val("ldr_flags",    F_FLAGS,    32'hA);

    go(); INSTRUCTION = 32'hEB000004;
    expect_val("bl_pcsrc",     F_PCSRC,    32'd1);
`ifdef ARM_CTRL_BL_EN
    expect_val("bl_regwrite",  F_REGWRITE, 32'd1);
    expect_val("bl_rdsrc",     F_RDSRC,    32'd1);
    expect_val("bl_wdsrc",     F_WDSRC,    32'd1);
`else
    expect_val("bl_regwrite",  F_REGWRITE, 32'd0);
    expect_val("bl_rdsrc",     F_RDSRC,    32'd0);
    expect_val("bl_wdsrc",     F_WDSRC,    32'd0);
`endif
    expect_val("bl_count",     F_CNT,      32'd6);

    go(); INSTRUCTION = 32'hEC000000; ALUFlags = 4'b0101;
    expect_val("und_pcsrc",    F_PCSRC,    32'd0);
    expect_val("und_regwrite", F_REGWRITE, 32'd0);
    expect_val("und_memwrite", F_MEMWRITE, 32'd0);
    expect_val("und_alusrc",   F_ALUSRC,   32'd0);
    expect_val("und_aluctl",   F_ALUCTL,   32'h0);
    expect_val("und_count",    F_CNT,      32'd7);

    go(); INSTRUCTION = 32'hF3A01005;
    expect_val("und_flags_held", F_FLAGS,    32'hA);
    expect_val("und_not_counted", F_CNT,     32'd7);
    expect_val("nv_regwrite",    F_REGWRITE, 32'd0);

    go(); INSTRUCTION = 32'hE3510000; ALUFlags = 4'b0011;
    expect_val("cmp_regwrite", F_REGWRITE, 32'd0);
    expect_val("nv_not_counted", F_CNT,    32'd7);

    go(); INSTRUCTION = 32'hC3A01005; ALUFlags = 4'b0000;
    expect_val("cmp_flags",    F_FLAGS,    32'h3);
    expect_val("gt_regwrite",  F_REGWRITE, 32'd0);
    expect_val("cmp_count",    F_CNT,      32'd8);

    go(); INSTRUCTION = 32'hB3A01005;
    expect_val("lt_regwrite",  F_REGWRITE, 32'd1);
    expect_val("gt_not_counted", F_CNT,    32'd8);

    go(); INSTRUCTION = 32'hE3A0F005;
    expect_val("movpc_pcsrc",  F_PCSRC,    32'd1);
    expect_val("movpc_count",  F_CNT,      32'd9);

    go(); INSTRUCTION = 32'hE2910001; ALUFlags = 4'b1111; reset = 1'b0;
    expect_val("midrst_regwrite", F_REGWRITE, 32'd0);
    expect_val("midrst_pcsrc",    F_PCSRC,    32'd0);
    expect_val("midrst_flags",    F_FLAGS,    32'h0);
    expect_val("midrst_count",    F_CNT,      32'd0);

    go(); reset = 1'b1;
    expect_val("rel_flags",    F_FLAGS,    32'h0);
    expect_val("rel_count",    F_CNT,      32'd0);
    expect_val("rel_regwrite", F_REGWRITE, 32'd1);

    go(); INSTRUCTION = 32'hEC000000; ALUFlags = 4'b0000;
    expect_val("adds_flags",   F_FLAGS,    32'hF);
    expect_val("adds_carryin", F_CARRYIN,  32'd1);
    expect_val("adds_count",   F_CNT,      32'd1);

    go(); INSTRUCTION = 32'hE3A01005;
    expect_val("wrap_start",   F_CNT4,     32'd1);
    for (int i = 0; i < 14; i++) go();
    expect_val("wrap_max4",    F_CNT4,     32'd15);
    expect_val("wrap_max32",   F_CNT,      32'd15);
    go();
    expect_val("wrap_zero4",   F_CNT4,     32'd0);
    expect_val("wrap_no32",    F_CNT,      32'd16);

    go(); INSTRUCTION = 32'hEC000000;
    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
